vga_timing_gen: RTL

//  Parametrised single-clock VGA/HDMI-style raster timing generator; successor to the fixed 720p controller.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_delay_line.sv | 29 ++
 rtl/vga_timing_gen.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Raster timing types, standard 720p/480p mode constants and colour type shared by the VGA timing generator.
package vga_pkg;

  typedef struct packed {
    int unsigned front;
    int unsigned sync;
    int unsigned back;
    int unsigned act;
  } vga_timing_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam vga_timing_t H_720P = '{front: 110, sync: 40, back: 220, act: 1280};
  localparam vga_timing_t V_720P = '{front: 5,   sync: 5,  back: 20,  act: 720};
  localparam vga_timing_t H_480P = '{front: 16,  sync: 96, back: 48,  act: 640};
  localparam vga_timing_t V_480P = '{front: 10,  sync: 2,  back: 33,  act: 480};

  function automatic int unsigned blank_len(input vga_timing_t t);
    return t.front + t.sync + t.back;
  endfunction

  function automatic int unsigned total_len(input vga_timing_t t);
    return blank_len(t) + t.act;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Async-reset shift register of DEPTH stages (DEPTH=0 is a wire); latency DEPTH cycles, no backpressure.
module vga_delay_line #(
  parameter int W     = 3,
  parameter int DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_dat,
  output logic [W-1:0] o_dat
);

  if (DEPTH == 0) begin : g_pass
    assign o_dat = i_dat;
  end else begin : g_pipe
    logic [W-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= i_dat;
        for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_dat = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: requests one cycle after the counters, DAC outputs 2+RD_LAT cycles after.
// Free-running, no backpressure; the host must return iColor exactly RD_LAT cycles after each request.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CW      = 12,
  parameter int H_FRONT = int'(H_720P.front),
  parameter int H_SYNC  = int'(H_720P.sync),
  parameter int H_BACK  = int'(H_720P.back),
  parameter int H_ACT   = int'(H_720P.act),
  parameter int V_FRONT = int'(V_720P.front),
  parameter int V_SYNC  = int'(V_720P.sync),
  parameter int V_BACK  = int'(V_720P.back),
  parameter int V_ACT   = int'(V_720P.act),
  parameter bit H_POL   = 1'b1,
  parameter bit V_POL   = 1'b1,
  parameter int RD_LAT  = 1
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic [23:0]   iColor,
  output logic          oRequest,
  output logic [CW-1:0] oCurrent_X,
  output logic [CW-1:0] oCurrent_Y,
  output logic          oFrameStart,
  output logic          oLineStart,
  output logic [7:0]    oVGA_R,
  output logic [7:0]    oVGA_G,
  output logic [7:0]    oVGA_B,
  output logic          oVGA_HS,
  output logic          oVGA_VS,
  output logic          oVGA_BLANK,
  output logic          oVGA_SYNC,
  output logic          oVGA_CLOCK
);

  localparam vga_timing_t H_T = '{front: H_FRONT, sync: H_SYNC, back: H_BACK, act: H_ACT};
  localparam vga_timing_t V_T = '{front: V_FRONT, sync: V_SYNC, back: V_BACK, act: V_ACT};
  localparam int H_BLANK = int'(blank_len(H_T));
  localparam int V_BLANK = int'(blank_len(V_T));
  localparam int H_TOTAL = int'(total_len(H_T));
  localparam int V_TOTAL = int'(total_len(V_T));

  if (((1 << CW) < H_TOTAL) || ((1 << CW) < V_TOTAL)) begin : g_cw_chk
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if ((RD_LAT < 0) || (RD_LAT > 8)) begin : g_lat_chk
    $error("vga_timing_gen: RD_LAT must be 0..8");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_BL   = CW'(H_BLANK);
  localparam logic [CW-1:0] V_BL   = CW'(V_BLANK);
  localparam logic [CW-1:0] H_SL   = CW'(H_FRONT);
  localparam logic [CW-1:0] H_SH   = CW'(H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_SL   = CW'(V_FRONT);
  localparam logic [CW-1:0] V_SH   = CW'(V_FRONT + V_SYNC);

  logic [CW-1:0] r_h, r_v;
  logic          w_act, w_hs, w_vs;
  logic          r_req, r_fs, r_ls;
  logic [CW-1:0] r_x, r_y;
  logic [2:0]    r_s1, w_dly;
  rgb_t          w_color, r_rgb;
  logic          r_blank, r_hs, r_vs;

  // Stage 0: raster counters, v advances only when h wraps
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == V_LAST) ? '0 : r_v + CW'(1);
    end else begin
      r_h <= r_h + CW'(1);
    end
  end

  assign w_act = (r_h >= H_BL) && (r_v >= V_BL);
  assign w_hs  = (r_h >= H_SL) && (r_h < H_SH);
  assign w_vs  = (r_v >= V_SL) && (r_v < V_SH);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_req <= 1'b0;
      r_x   <= '0;
      r_y   <= '0;
      r_fs  <= 1'b0;
      r_ls  <= 1'b0;
      r_s1  <= '0;
    end else begin
      r_req <= w_act;
      r_x   <= w_act ? r_h - H_BL : '0;
      r_y   <= w_act ? r_v - V_BL : '0;
      r_fs  <= w_act && (r_h == H_BL) && (r_v == V_BL);
      r_ls  <= w_act && (r_h == H_BL);
      r_s1  <= {w_act, w_hs, w_vs};
    end
  end

  // Hold {act,hs,vs} back by the host read latency so they meet the returning colour
  vga_delay_line #(.W(3), .DEPTH(RD_LAT)) u_align (
    .i_clk   (iCLK),
    .i_rst_n (iRST_N),
    .i_dat   (r_s1),
    .o_dat   (w_dly)
  );

  assign w_color = iColor;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_rgb   <= '0;
      r_blank <= 1'b0;
      r_hs    <= ~H_POL;
      r_vs    <= ~V_POL;
    end else begin
      r_rgb   <= w_dly[2] ? w_color : '0;
      r_blank <= w_dly[2];
      r_hs    <= w_dly[1] ? H_POL : ~H_POL;
      r_vs    <= w_dly[0] ? V_POL : ~V_POL;
    end
  end

  assign oRequest    = r_req;
  assign oCurrent_X  = r_x;
  assign oCurrent_Y  = r_y;
  assign oFrameStart = r_fs;
  assign oLineStart  = r_ls;
  assign oVGA_R      = r_rgb.r;
  assign oVGA_G      = r_rgb.g;
  assign oVGA_B      = r_rgb.b;
  assign oVGA_HS     = r_hs;
  assign oVGA_VS     = r_vs;
  assign oVGA_BLANK  = r_blank;
  assign oVGA_SYNC   = 1'b1;
  assign oVGA_CLOCK  = iCLK;

endmodule
